// File: rtl/dividend_reconstructor_stg.sv
// Sequential shift-add dividend reconstructor.
// Rebuilds dividend = quotient * divisor + remainder from a divider's outputs,
// using a Start/Ready handshake and a Moore state machine.
module dividend_reconstructor_stg #(
  parameter int L_divn = 8,
  parameter int L_divr = 4,
  parameter int L_cnt  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     Start,
  input  logic [L_divn-1:0]        quotient,
  input  logic [L_divr-1:0]        divisor,
  input  logic [L_divr-1:0]        remainder,
  output logic [L_divn+L_divr-1:0] dividend,
  output logic                     Ready,
  output logic                     Done,
  output logic                     Error
);

  localparam int W = L_divn + L_divr;

  typedef enum logic [1:0] {
    S_idle   = 2'd0,
    S_Mul    = 2'd1,
    S_AddRem = 2'd2,
    S_Err    = 2'd3
  } state_t;

  state_t            state;
  state_t            next_state;

  logic [W-1:0]      acc;
  logic [W-1:0]      mcand;
  logic [L_divr-1:0] mplr;
  logic [L_cnt-1:0]  cnt;
  logic [L_divr-1:0] rem_r;

  logic              bad_op;
  logic              last_bit;

  // Operand legality and multiply-loop termination flags
  always_comb begin
    bad_op   = (divisor == '0) || (remainder >= divisor);
    last_bit = (cnt == L_cnt'(L_divr - 1));
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_idle;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_idle: begin
        if (Start) begin
          if (bad_op) next_state = S_Err;
          else        next_state = S_Mul;
        end
      end
      S_Mul:    if (last_bit) next_state = S_AddRem;
      S_AddRem: next_state = S_idle;
      S_Err:    next_state = S_Err;
      default:  next_state = S_idle;
    endcase
  end

  // Moore outputs; Ready is also masked during the reset cycle
  always_comb begin
    Ready = (state == S_idle) && !reset;
    Error = (state == S_Err);
  end

  // Datapath: load on accept, shift-add for L_divr cycles, then add remainder
  always_ff @(posedge clock) begin
    if (reset) begin
      acc      <= '0;
      mcand    <= '0;
      mplr     <= '0;
      cnt      <= '0;
      rem_r    <= '0;
      dividend <= '0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_idle: begin
          if (Start && !bad_op) begin
            acc   <= '0;
            mcand <= {{L_divr{1'b0}}, quotient};
            mplr  <= divisor;
            rem_r <= remainder;
            cnt   <= '0;
          end
        end
        S_Mul: begin
          if (mplr[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 1'b1;
        end
        S_AddRem: begin
          dividend <= acc + W'(rem_r);
          Done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dividend_reconstructor_stg.sv
// Scoreboard bench for dividend_reconstructor_stg: driver pushes q*d+r for
// every accepted operation, an independent monitor pops on each Done pulse.
module tb_dividend_reconstructor_stg;

  localparam int LN = 8;
  localparam int LR = 4;
  localparam int W  = LN + LR;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          Start = 1'b0;
  logic [LN-1:0] quotient = '0;
  logic [LR-1:0] divisor = '0;
  logic [LR-1:0] remainder = '0;
  logic [W-1:0]  dividend;
  logic          Ready, Done, Error;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  dividend_reconstructor_stg #(.L_divn(LN), .L_divr(LR), .L_cnt(4)) dut (
    .clock(clock), .reset(reset), .Start(Start), .quotient(quotient),
    .divisor(divisor), .remainder(remainder), .dividend(dividend),
    .Ready(Ready), .Done(Done), .Error(Error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every Done pulse must match the oldest outstanding operation
  always @(negedge clock) begin
    if (!reset && Done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got dividend %0d expected no Done", dividend);
      end else begin
        check("dividend", int'(dividend), exp_q.pop_front());
        check("ready_with_done", int'(Ready), 1);
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int n = 0;
    ok = 1;
    while (!Ready) begin
      tick();
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: got Ready 0 expected 1 within 50 cycles");
        ok = 0;
        return;
      end
    end
  endtask

  // Issue one valid operation and record its reference result
  task automatic issue(input int q, input int d, input int r);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    quotient  = LN'(q);
    divisor   = LR'(d);
    remainder = LR'(r);
    Start     = 1'b1;
    exp_q.push_back(q * d + r);
    tick();
    Start = 1'b0;
  endtask

  // Count busy cycles after an accept until Ready returns
  task automatic busy_len(output int n);
    n = 0;
    while (!Ready && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    bit ok;
    int saved;

    // Reset state, with Ready masked while reset is high
    tick(); tick();
    check("reset_ready", int'(Ready), 0);
    check("reset_dividend", int'(dividend), 0);
    check("reset_done", int'(Done), 0);
    check("reset_error", int'(Error), 0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", int'(Ready), 1);

    // 13*7+5 with busy-length measurement
    issue(13, 7, 5);
    busy_len(n);
    check("busy_cycles", n, 5);
    check("done_in_ready_cycle", int'(Done), 1);
    tick();
    check("done_single_pulse", int'(Done), 0);

    // Full-scale operands: carry into the top bits
    issue(255, 15, 14);
    busy_len(n);
    check("busy_cycles_max", n, 5);
    drain();

    // Back-to-back: second Start held and accepted in the Done cycle
    issue(200, 1, 0);
    quotient = 8'd0; divisor = 4'd9; remainder = 4'd8; Start = 1'b1;
    wait_ready(ok);
    check("accept_in_done_cycle", int'(Done), 1);
    exp_q.push_back(8);
    tick();
    Start = 1'b0;
    drain();
    saved = int'(dividend);

    // Start re-pulsed with new operands during S_Mul is ignored
    issue(77, 11, 3);
    tick();
    quotient = 8'd5; divisor = 4'd2; remainder = 4'd1; Start = 1'b1;
    tick();
    Start = 1'b0;
    drain();
    check("ignored_restart_idle", int'(Ready), 1);
    saved = int'(dividend);

    // Illegal operands: divisor 0
    wait_ready(ok);
    quotient = 8'd50; divisor = 4'd0; remainder = 4'd0; Start = 1'b1;
    tick();
    Start = 1'b0;
    check("err_div0", int'(Error), 1);
    check("err_div0_ready", int'(Ready), 0);
    check("err_div0_hold", int'(dividend), saved);
    for (int i = 0; i < 10; i++) begin
      quotient = LN'($urandom); divisor = 4'd3; remainder = 4'd1; Start = 1'b1;
      tick();
      Start = 1'b0;
      tick();
    end
    check("err_sticky", int'(Error), 1);
    check("err_sticky_ready", int'(Ready), 0);
    check("err_sticky_hold", int'(dividend), saved);
    reset = 1'b1; tick(); reset = 1'b0; #1;
    check("err_cleared", int'(Error), 0);
    check("err_cleared_ready", int'(Ready), 1);

    // Illegal operands: remainder == divisor
    quotient = 8'd3; divisor = 4'd7; remainder = 4'd7; Start = 1'b1;
    tick();
    Start = 1'b0;
    check("err_rem_eq_div", int'(Error), 1);
    check("err_rem_hold", int'(dividend), 0);
    reset = 1'b1; tick(); reset = 1'b0; #1;

    // Reset landing on the 2nd multiply cycle aborts with no Done
    issue(13, 7, 5);
    tick();
    reset = 1'b1;
    void'(exp_q.pop_back());
    tick();
    reset = 1'b0;
    #1;
    check("abort_dividend", int'(dividend), 0);
    check("abort_ready", int'(Ready), 1);
    check("abort_no_done", int'(Done), 0);
    issue(13, 7, 5);
    drain();

    // Randomized legal operations with random idle gaps
    for (int i = 0; i < 40; i++) begin
      int d = $urandom_range(15, 1);
      int r = $urandom_range(d - 1, 0);
      int q = $urandom_range(255, 0);
      issue(q, d, r);
      repeat ($urandom_range(7, 0)) tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
